mult_div_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Takes the MULT/MULTU/DIV/DIVU work that the ALU does not handle, and returns the 64-bit result as HI/LO.
- The controller issues requests with a start/busy/done handshake and stalls while busy_o is high.

---
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 tb/tb_mult_div_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, HI/LO result.
// Optional macro MDU_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic                 accept, iterate, finish, last_iter;
    logic                 is_div_q, neg_lo_q, neg_hi_q, dz_q;
    logic [2*WIDTH-1:0]   acc_q, mcand_q;
    logic [WIDTH-1:0]     b_q;
    logic [CW-1:0]        cnt_q;

    logic                 s1_neg, s2_neg, src2_zero;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [2*WIDTH-1:0]   mul_sum, prod;
    logic [WIDTH:0]       div_top, div_diff;
    logic [WIDTH-1:0]     quo, rem;

    // Operand magnitudes; op_i[0] selects the signed variants.
    assign s1_neg    = op_i[0] & src1_i[WIDTH-1];
    assign s2_neg    = op_i[0] & src2_i[WIDTH-1];
    assign mag1      = s1_neg ? -src1_i : src1_i;
    assign mag2      = s2_neg ? -src2_i : src2_i;
    assign src2_zero = (src2_i == '0);

    // The multiplicand is shifted left instead of the accumulator right,
    // so the accumulator is always in final alignment when RUN is left early.
    assign mul_sum  = acc_q + (b_q[0] ? mcand_q : '0);
    assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_top - {1'b0, b_q};

    assign prod = neg_lo_q ? -acc_q : acc_q;
    assign quo  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_EARLY_OUT_EN
    assign last_iter = (cnt_q == CW'(WIDTH-1)) || (!is_div_q && (b_q[WIDTH-1:1] == '0));
`else
    assign last_iter = (cnt_q == CW'(WIDTH-1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: defaults first so no path through the case leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (op_i[1] && src2_zero) ? FIX : RUN;
            RUN:     if (last_iter) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q != IDLE);
        accept  = (state_q == IDLE) && start_i;
        iterate = (state_q == RUN);
        finish  = (state_q == FIX);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            done_o     <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            div_zero_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                is_div_q <= op_i[1];
                dz_q     <= op_i[1] & src2_zero;
                neg_lo_q <= s1_neg ^ s2_neg;
                neg_hi_q <= op_i[1] ? s1_neg : (s1_neg ^ s2_neg);
                b_q      <= mag2;
                cnt_q    <= '0;
                if (op_i[1]) begin
                    acc_q   <= {{WIDTH{1'b0}}, mag1};
                    mcand_q <= {{WIDTH{1'b0}}, src1_i};   // raw dividend kept for divide by zero
                end else begin
                    acc_q   <= '0;
                    mcand_q <= {{WIDTH{1'b0}}, mag1};
                end
            end else if (iterate) begin
                cnt_q <= cnt_q + 1'b1;
                if (is_div_q) begin
                    if (!div_diff[WIDTH])
                        acc_q <= {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_q <= {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    acc_q   <= mul_sum;
                    mcand_q <= mcand_q << 1;
                    b_q     <= b_q >> 1;
                end
            end else if (finish) begin
                done_o     <= 1'b1;
                div_zero_o <= dz_q;
                if (dz_q) begin
                    hi_o <= mcand_q[WIDTH-1:0];
                    lo_o <= '1;
                end else if (is_div_q) begin
                    hi_o <= rem;
                    lo_o <= quo;
                end else begin
                    hi_o <= prod[2*WIDTH-1:WIDTH];
                    lo_o <= prod[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
// Expected multiply latencies follow MDU_EARLY_OUT_EN when it is defined.
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'b00;
    logic [W-1:0] src1_i = '0;
    logic [W-1:0] src2_i = '0;
    logic         busy_o, done_o, div_zero_o;
    logic [W-1:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 of the cycle after acceptance; returns in the done_o cycle.
    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (!done_o && n < 200);
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " busy in done cycle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int exp_lat,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic exp_dz);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check({tag, " busy after accept"}, 64'(busy_o), 64'd1);
        wait_done(tag, exp_lat);
        check({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
        check({tag, " div_zero"}, 64'(div_zero_o), 64'(exp_dz));
    endtask

    initial begin
        int n;
        int pulses;

        #12;
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset hi", 64'(hi_o), 64'd0);
        check("reset lo", 64'(lo_o), 64'd0);
        check("reset dz", 64'(div_zero_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        do_op("multu max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op("mult -3*5",  2'b01, 32'hFFFFFFFD, 32'h00000005, EARLY ? 4 : 33,
              32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        do_op("div -7/2",   2'b11, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op("divu 100/7", 2'b10, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
        do_op("divu 100/0", 2'b10, 32'd100, 32'd0, 1, 32'd100, 32'hFFFFFFFF, 1'b1);
        do_op("div 7/-2",   2'b11, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD, 1'b0);
        do_op("div ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000, 1'b0);
        do_op("mult -1*-1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, EARLY ? 2 : 33, 32'd0, 32'd1, 1'b0);

        // start_i held high with operands changing every busy cycle
        start_i = 1'b1;
        op_i    = 2'b00;
        src1_i  = 32'd3;
        src2_i  = 32'd4;
        @(posedge clk_i); #1;
        check("hold busy after accept", 64'(busy_o), 64'd1);
        n = 0;
        do begin
            op_i   = 2'($urandom_range(0, 3));
            src1_i = $urandom;
            src2_i = $urandom;
            @(posedge clk_i); #1;
            n++;
        end while (!done_o && n < 200);
        check("hold latency", 64'(n), EARLY ? 64'd4 : 64'd33);
        check("hold hi", 64'(hi_o), 64'd0);
        check("hold lo", 64'(lo_o), 64'd12);
        // request presented in the done cycle is taken at the next edge
        op_i   = 2'b10;
        src1_i = 32'd100;
        src2_i = 32'd7;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("b2b busy after accept", 64'(busy_o), 64'd1);
        wait_done("b2b divu", 33);
        check("b2b hi", 64'(hi_o), 64'd2);
        check("b2b lo", 64'(lo_o), 64'd14);

        // reset during iteration 10 of a divide
        start_i = 1'b1;
        op_i    = 2'b10;
        src1_i  = 32'd1000;
        src2_i  = 32'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("mid reset busy", 64'(busy_o), 64'd0);
        check("mid reset done", 64'(done_o), 64'd0);
        check("mid reset hi", 64'(hi_o), 64'd0);
        check("mid reset lo", 64'(lo_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (done_o) pulses++;
        end
        check("no done after reset", 64'(pulses), 64'd0);

        do_op("multu 6*7", 2'b00, 32'd6, 32'd7, EARLY ? 4 : 33, 32'd0, 32'd42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
